// File: rtl/tourn_bht.sv
// Tournament branch direction predictor: gshare global PHT, two-level local PHT and a chooser table.
// Optional same-cycle update-to-lookup forwarding is enabled by defining TOURN_BHT_BYPASS_EN.
`timescale 1ns/1ps
module tourn_bht #(
   parameter int unsigned VLEN        = 64,
   parameter int unsigned PHT_ENTRIES = 1024,
   parameter int unsigned LHT_ENTRIES = 256,
   parameter int unsigned GHIST_LEN   = 10,
   parameter int unsigned LHIST_LEN   = 10,
   parameter int unsigned CTR_BITS    = 2,
   parameter int unsigned OFFSET      = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            lookup_valid_i,
   input  logic [VLEN-1:0] lookup_pc_i,
   output logic            predict_valid_o,
   output logic            predict_taken_o,
   output logic            predict_src_o,
   input  logic            update_valid_i,
   input  logic [VLEN-1:0] update_pc_i,
   input  logic            update_taken_i,
   output logic            ready_o
);

   localparam int unsigned GIDX_W       = $clog2(PHT_ENTRIES);
   localparam int unsigned LIDX_W       = $clog2(LHT_ENTRIES);
   localparam int unsigned LPHT_ENTRIES = 32'd1 << LHIST_LEN;
   localparam int unsigned ROWS_A       = (PHT_ENTRIES > LHT_ENTRIES) ? PHT_ENTRIES : LHT_ENTRIES;
   localparam int unsigned ROWS         = (ROWS_A > LPHT_ENTRIES) ? ROWS_A : LPHT_ENTRIES;
   localparam int unsigned ROW_W        = $clog2(ROWS);

   localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

   typedef enum logic {INIT, READY} state_t;

   function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr,
                                                    input logic up);
      logic [CTR_BITS-1:0] res;
      res = ctr;
      if (up && (ctr != CTR_MAX))
         res = ctr + CTR_ONE;
      else if (!up && (ctr != '0))
         res = ctr - CTR_ONE;
      return res;
   endfunction

   // Chooser only learns when the two components disagree; up means "trust global".
   function automatic logic [CTR_BITS-1:0] chooser_step(input logic [CTR_BITS-1:0] ctr,
                                                        input logic g_pred,
                                                        input logic l_pred,
                                                        input logic taken);
      logic [CTR_BITS-1:0] res;
      res = ctr;
      if (g_pred != l_pred)
         res = sat_step(ctr, g_pred == taken);
      return res;
   endfunction

   function automatic logic [GIDX_W-1:0] fold_ghist(input logic [GHIST_LEN-1:0] h);
      logic [GIDX_W+GHIST_LEN-1:0] ext;
      ext = {{GIDX_W{1'b0}}, h};
      return ext[GIDX_W-1:0];
   endfunction

   state_t              state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                init_wr;
   logic [GHIST_LEN-1:0] ghist_q, ghist_d;

   logic [CTR_BITS-1:0]  gpht_q [PHT_ENTRIES];
   logic [CTR_BITS-1:0]  cpht_q [PHT_ENTRIES];
   logic [CTR_BITS-1:0]  lpht_q [LPHT_ENTRIES];
   logic [LHIST_LEN-1:0] lht_q  [LHT_ENTRIES];

   logic                 up_en;
   logic [GIDX_W-1:0]    up_gidx, up_cidx;
   logic [LIDX_W-1:0]    up_lidx;
   logic [LHIST_LEN-1:0] up_lpidx;
   logic [CTR_BITS-1:0]  up_g_old, up_l_old, up_c_old;
   logic [CTR_BITS-1:0]  up_g_new, up_l_new, up_c_new;

   logic                 lk_en_p0;
   logic [GIDX_W-1:0]    lk_gidx_p0, lk_cidx_p0;
   logic [LIDX_W-1:0]    lk_lidx_p0;
   logic [LHIST_LEN-1:0] lk_lpidx_p0;
   logic [CTR_BITS-1:0]  lk_g_p0, lk_l_p0, lk_c_p0;
   logic                 lk_taken_p0, lk_src_p0;

   logic vld_p1, taken_p1, src_p1;
   logic unused_pc_bits;

   assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= INIT;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      init_wr = 1'b0;
      case (state_q)
         INIT: begin
            init_wr = 1'b1;
            if (row_q == ROW_LAST)
               state_d = READY;
            else
               row_d = row_q + ROW_W'(1);
         end
         READY: ;
         default: state_d = INIT;
      endcase
   end

   assign up_en    = update_valid_i && (state_q == READY);
   assign lk_en_p0 = lookup_valid_i && (state_q == READY);

   // Update path: indices from the history as it stands before this update.
   always_comb begin
      up_cidx  = update_pc_i[OFFSET+GIDX_W-1:OFFSET];
      up_gidx  = up_cidx ^ fold_ghist(ghist_q);
      up_lidx  = update_pc_i[OFFSET+LIDX_W-1:OFFSET];
      up_lpidx = lht_q[up_lidx];
      up_g_old = gpht_q[up_gidx];
      up_l_old = lpht_q[up_lpidx];
      up_c_old = cpht_q[up_cidx];
      up_g_new = sat_step(up_g_old, update_taken_i);
      up_l_new = sat_step(up_l_old, update_taken_i);
      up_c_new = chooser_step(up_c_old, up_g_old[CTR_BITS-1], up_l_old[CTR_BITS-1],
                              update_taken_i);
   end

   // Flush wins over the history shift; the table writes of the same update still land.
   always_comb begin
      ghist_d = ghist_q;
      if (state_q == READY) begin
         if (flush_i)
            ghist_d = '0;
         else if (update_valid_i)
            ghist_d = {ghist_q[GHIST_LEN-2:0], update_taken_i};
      end
   end

   // ---- stage p0: lookup index and table read ----
   always_comb begin
      lk_cidx_p0  = lookup_pc_i[OFFSET+GIDX_W-1:OFFSET];
      lk_gidx_p0  = lk_cidx_p0 ^ fold_ghist(ghist_q);
      lk_lidx_p0  = lookup_pc_i[OFFSET+LIDX_W-1:OFFSET];
      lk_lpidx_p0 = lht_q[lk_lidx_p0];
`ifdef TOURN_BHT_BYPASS_EN
      lk_g_p0 = (up_en && (up_gidx == lk_gidx_p0))   ? up_g_new : gpht_q[lk_gidx_p0];
      lk_l_p0 = (up_en && (up_lpidx == lk_lpidx_p0)) ? up_l_new : lpht_q[lk_lpidx_p0];
      lk_c_p0 = (up_en && (up_cidx == lk_cidx_p0))   ? up_c_new : cpht_q[lk_cidx_p0];
`else
      lk_g_p0 = gpht_q[lk_gidx_p0];
      lk_l_p0 = lpht_q[lk_lpidx_p0];
      lk_c_p0 = cpht_q[lk_cidx_p0];
`endif
      lk_src_p0   = lk_c_p0[CTR_BITS-1];
      lk_taken_p0 = lk_src_p0 ? lk_g_p0[CTR_BITS-1] : lk_l_p0[CTR_BITS-1];
   end

   // ---- stage p1: registered prediction and history ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ghist_q  <= '0;
         vld_p1   <= 1'b0;
         taken_p1 <= 1'b0;
         src_p1   <= 1'b0;
      end else begin
         ghist_q  <= ghist_d;
         vld_p1   <= lk_en_p0;
         taken_p1 <= lk_taken_p0;
         src_p1   <= lk_src_p0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (init_wr) begin
         if (32'(row_q) < PHT_ENTRIES) begin
            gpht_q[row_q[GIDX_W-1:0]] <= CTR_INIT;
            cpht_q[row_q[GIDX_W-1:0]] <= CTR_INIT;
         end
         if (32'(row_q) < LHT_ENTRIES)
            lht_q[row_q[LIDX_W-1:0]] <= '0;
         if (32'(row_q) < LPHT_ENTRIES)
            lpht_q[row_q[LHIST_LEN-1:0]] <= CTR_INIT;
      end else if (up_en) begin
         gpht_q[up_gidx]  <= up_g_new;
         lpht_q[up_lpidx] <= up_l_new;
         cpht_q[up_cidx]  <= up_c_new;
         lht_q[up_lidx]   <= {up_lpidx[LHIST_LEN-2:0], update_taken_i};
      end
   end

   assign predict_valid_o = vld_p1;
   assign predict_taken_o = taken_p1;
   assign predict_src_o   = src_p1;
   assign ready_o         = (state_q == READY);

endmodule

// File: tb/tb_tourn_bht.sv
// Directed bench for tourn_bht with default parameters; expected values worked out by hand
// from the table/history evolution noted next to each step.
`timescale 1ns/1ps
module tb_tourn_bht;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        lookup_valid_i;
   logic [63:0] lookup_pc_i;
   logic        predict_valid_o;
   logic        predict_taken_o;
   logic        predict_src_o;
   logic        update_valid_i;
   logic [63:0] update_pc_i;
   logic        update_taken_i;
   logic        ready_o;

   int total = 0;
   int bad   = 0;

`ifdef TOURN_BHT_BYPASS_EN
   localparam logic BYP_EXP = 1'b1;
`else
   localparam logic BYP_EXP = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   tourn_bht dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .lookup_valid_i  (lookup_valid_i),
      .lookup_pc_i     (lookup_pc_i),
      .predict_valid_o (predict_valid_o),
      .predict_taken_o (predict_taken_o),
      .predict_src_o   (predict_src_o),
      .update_valid_i  (update_valid_i),
      .update_pc_i     (update_pc_i),
      .update_taken_i  (update_taken_i),
      .ready_o         (ready_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic upd(input logic [63:0] pc, input logic t);
      update_valid_i = 1'b1;
      update_pc_i    = pc;
      update_taken_i = t;
      tick();
      update_valid_i = 1'b0;
   endtask

   task automatic look(input logic [63:0] pc);
      lookup_valid_i = 1'b1;
      lookup_pc_i    = pc;
      tick();
      lookup_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int start);
      int n;
      n = start;
      while (!ready_o && n < 2000) begin
         tick();
         n++;
      end
      check(tag, n, 1024);
   endtask

   initial begin
      rst_ni         = 1'b0;
      flush_i        = 1'b0;
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 64'h8000_0000;
      update_valid_i = 1'b0;
      update_pc_i    = '0;
      update_taken_i = 1'b0;
      repeat (3) tick();
      check("rst_ready", ready_o, 0);
      check("rst_valid", predict_valid_o, 0);
      check("rst_taken", predict_taken_o, 0);
      check("rst_src", predict_src_o, 0);

      // First INIT cycle: lookup and taken update both ignored.
      rst_ni         = 1'b1;
      update_valid_i = 1'b1;
      update_pc_i    = 64'h1234;
      update_taken_i = 1'b1;
      tick();
      check("init_lookup_valid", predict_valid_o, 0);
      lookup_valid_i = 1'b0;
      update_valid_i = 1'b0;
      wait_ready("init_len", 1);

      // Fresh tables: everything weakly not-taken, chooser weakly local.
      look(64'h8000_0000);
      check("first_valid", predict_valid_o, 1);
      check("first_taken", predict_taken_o, 0);
      check("first_src", predict_src_o, 0);
      tick();
      check("idle_valid", predict_valid_o, 0);

      // PC 0x1000 indexes row 0; history walks 0,1,3..0x1FF so after ten updates
      // the entry at history 0x3FF is still untouched (1) -> not taken.
      for (int i = 0; i < 10; i++) upd(64'h1000, 1'b1);
      look(64'h1000);
      check("t10_valid", predict_valid_o, 1);
      check("t10_taken", predict_taken_o, 0);
      // Four more hit history 0x3FF: 1->2->3->3->3 (a wrap would leave 1).
      for (int i = 0; i < 4; i++) upd(64'h1000, 1'b1);
      look(64'h1000);
      check("t14_taken", predict_taken_o, 1);
      check("t14_src", predict_src_o, 0);

      // Reset while a lookup is pending drops the prediction.
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 64'h1000;
      rst_ni         = 1'b0;
      tick();
      check("midrst_valid", predict_valid_o, 0);
      check("midrst_ready", ready_o, 0);
      lookup_valid_i = 1'b0;
      rst_ni         = 1'b1;
      wait_ready("reinit_len", 0);

      // Alternating T/N on 0x2000: history settles to 0x2AA (next T, ctr 3) and 0x155 (next N, ctr 0).
      for (int i = 0; i < 20; i++) upd(64'h2000, (i % 2) == 0);
      look(64'h2000);
      check("alt_taken", predict_taken_o, 1);
      check("alt_src", predict_src_o, 0);
      upd(64'h2000, 1'b1);
      look(64'h2000);
      check("alt2_taken", predict_taken_o, 0);
      check("alt2_src", predict_src_o, 0);

      // Flush: ghist 0, local history 0x155. Global[0]=2 (T) vs local[0x155]=0 (N).
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      look(64'h2000);
      check("flush_taken", predict_taken_o, 0);
      check("flush_src", predict_src_o, 0);
      // Taken update: global right, local wrong -> chooser 1->2 (global).
      upd(64'h2000, 1'b1);
      look(64'h2000);
      check("chooser_src", predict_src_o, 1);
      check("chooser_taken", predict_taken_o, 0);
      // Flush with update: ghist 0 (not 3), so global[0]=3 is read.
      flush_i = 1'b1;
      upd(64'h2000, 1'b1);
      flush_i = 1'b0;
      look(64'h2000);
      check("flushupd_taken", predict_taken_o, 1);
      check("flushupd_src", predict_src_o, 1);

      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      wait_ready("reinit2_len", 0);

      // Same-cycle update T and lookup on 0x3000 with all counters at 1.
      update_valid_i = 1'b1;
      update_pc_i    = 64'h3000;
      update_taken_i = 1'b1;
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 64'h3000;
      tick();
      update_valid_i = 1'b0;
      lookup_valid_i = 1'b0;
      check("byp_valid", predict_valid_o, 1);
      check("byp_taken", predict_taken_o, BYP_EXP);
      check("byp_src", predict_src_o, 0);
      // 0x3002 with ghist 1 reads global[0] and local row 1 -> local PHT[0], both now 2.
      look(64'h3002);
      check("after_taken", predict_taken_o, 1);
      check("after_src", predict_src_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
